// File: rtl/shared_net_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// shared_net_rr_arbiter_if
//   Bundle of signals between NREQ requesters and the round-robin arbiter that
//   owns the shared buffered drive net.
//
//   Parameters:
//     NREQ : number of requesters
//     DW   : data width of the shared net
//
//   Signals:
//     req       requester -> arbiter  request, one bit per requester (level)
//     rel       requester -> arbiter  release strobe from the current owner
//     data_in   requester -> arbiter  packed requester data, slice i = [i*DW +: DW]
//     gnt       arbiter -> requester  one-hot grant
//     owner     arbiter -> requester  index of current/last owner
//     net_out   arbiter -> loads      shared net data
//     net_valid arbiter -> loads      net_out carries owner data this cycle
//     busy      arbiter -> observer   arbiter not idle
//     tmo_pulse arbiter -> observer   one-cycle pulse on forced release
//
//   Modports:
//     master : requester side (drives req/rel/data_in)
//     slave  : arbiter side (drives grant and net outputs)
// ---------------------------------------------------------------------------
interface shared_net_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         rel;
    logic [NREQ*DW-1:0]      data_in;
    logic [NREQ-1:0]         gnt;
    logic [$clog2(NREQ)-1:0] owner;
    logic [DW-1:0]           net_out;
    logic                    net_valid;
    logic                    busy;
    logic                    tmo_pulse;

    modport master (
        output req, rel, data_in,
        input  gnt, owner, net_out, net_valid, busy, tmo_pulse
    );

    modport slave (
        input  req, rel, data_in,
        output gnt, owner, net_out, net_valid, busy, tmo_pulse
    );
endinterface

// File: rtl/shared_net_rr_arbiter.sv
// ---------------------------------------------------------------------------
// shared_net_rr_arbiter
//   Round-robin scheduler sharing one buffered drive net among NREQ
//   requesters. One owner is granted at a time, its data is registered onto
//   net_out, and a turnaround bubble separates owners so the loads behind the
//   shared buffer tree never see a mixed word. Loads sample net_out only when
//   net_valid is high.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous, active-high reset
//     bus  : shared_net_rr_arbiter_if.slave (req, rel, data_in in;
//            gnt, owner, net_out, net_valid, busy, tmo_pulse out)
//
//   Parameters:
//     NREQ    : requesters (2..16)
//     DW      : net data width
//     TMO_MAX : grant length limit in cycles (only with ARB_TIMEOUT_EN)
//
//   Build option:
//     ARB_TIMEOUT_EN : when defined, an owner holding the net for TMO_MAX
//                      valid cycles is forcibly released and tmo_pulse fires.
//                      When undefined, a grant lasts until rel or req drops
//                      and tmo_pulse is tied low.
// ---------------------------------------------------------------------------
module shared_net_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TMO_MAX = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    shared_net_rr_arbiter_if.slave  bus
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_next;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   owner_next;
    logic [IW-1:0]   after_owner;
    logic [IW-1:0]   winner;
    logic            win_found;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] gnt_next;
    logic [DW-1:0]   net_q;
    logic [DW-1:0]   net_next;
    logic            valid_q;
    logic            valid_next;
    logic            timeout;
    logic            leave;

    // Modular priority scan: the first requester at or after ptr wins, so the
    // most recent owner (ptr was moved past it) is the last one considered.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && bus.req[(int'(ptr) + k) % NREQ]) begin
                win_found = 1'b1;
                winner    = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign after_owner = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_MAX + 1);

    logic [CW-1:0] hold_cnt;
    logic          tmo_q;

    // Hold-length counter: zero in the first HOLD cycle, counting up while the
    // owner keeps the net. The pulse register fires in the cycle after the
    // forced release, i.e. exactly once per timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            tmo_q    <= 1'b0;
        end else begin
            hold_cnt <= (state == HOLD) ? hold_cnt + CW'(1) : '0;
            tmo_q    <= timeout;
        end
    end

    assign timeout       = (state == HOLD) && (hold_cnt == CW'(TMO_MAX - 1));
    assign bus.tmo_pulse = tmo_q;
`else
    logic tmo_unused;

    assign tmo_unused    = ^TMO_MAX;
    assign timeout       = 1'b0;
    assign bus.tmo_pulse = 1'b0;
`endif

    // Only the owner's own release or request drop ends its grant; rel bits
    // from other requesters are deliberately ignored.
    assign leave = bus.rel[owner_q] || !bus.req[owner_q] || timeout;

    // State and output registers; reset overrides everything, so a grant in
    // progress is dropped on the next edge without a turnaround cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            net_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            owner_q <= owner_next;
            gnt_q   <= gnt_next;
            net_q   <= net_next;
            valid_q <= valid_next;
        end
    end

    // Next-state and next-output logic. GRANT is a settle cycle with the net
    // still invalid; TURN is the single bubble between owners. Together they
    // give the two-cycle net_valid gap at every handoff.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner_q;
        gnt_next   = gnt_q;
        net_next   = net_q;
        valid_next = 1'b0;

        case (state)
            IDLE, TURN: begin
                gnt_next = '0;
                if (win_found) begin
                    state_next       = GRANT;
                    owner_next       = winner;
                    gnt_next[winner] = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                state_next = HOLD;
                net_next   = bus.data_in[int'(owner_q)*DW +: DW];
                valid_next = 1'b1;
            end
            HOLD: begin
                if (leave) begin
                    state_next = TURN;
                    gnt_next   = '0;
                    ptr_next   = after_owner;
                end else begin
                    net_next   = bus.data_in[int'(owner_q)*DW +: DW];
                    valid_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.owner     = owner_q;
    assign bus.net_out   = net_q;
    assign bus.net_valid = valid_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_shared_net_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shared_net_rr_arbiter
//   Self-checking bench for shared_net_rr_arbiter (NREQ=4, DW=8, TMO_MAX=16).
//   Each vector holds the inputs for one clock cycle and the outputs expected
//   right after the following rising edge. Expected records are queued when
//   the stimulus is driven and popped for comparison once the edge has passed.
// ---------------------------------------------------------------------------
module tb_shared_net_rr_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TMO_MAX = 16;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req;
        logic [3:0] rel;
        logic [31:0] data;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic [7:0] net;
        logic       valid;
        logic       busy;
        logic       tmo;
    } vec_t;

    logic clk;
    logic rst;

    int tests_run;
    int tests_failed;

    vec_t vecs[$];
    vec_t scoreboard[$];

    shared_net_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    shared_net_rr_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TMO_MAX (TMO_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue one vector: inputs for a cycle plus outputs expected after its edge.
    task automatic add_vec(input string name, input logic r, input logic [3:0] req,
                           input logic [3:0] rel, input logic [31:0] data,
                           input logic [3:0] gnt, input logic [1:0] owner,
                           input logic [7:0] net, input logic valid,
                           input logic busy, input logic tmo);
        vec_t v;
        v.name  = name;
        v.rst   = r;
        v.req   = req;
        v.rel   = rel;
        v.data  = data;
        v.gnt   = gnt;
        v.owner = owner;
        v.net   = net;
        v.valid = valid;
        v.busy  = busy;
        v.tmo   = tmo;
        vecs.push_back(v);
    endtask

    task automatic check_field(input string name, input string field,
                               input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, field, actual, expected);
        end
    endtask

    task automatic checkOutput(input vec_t e);
        check_field(e.name, "gnt",       32'(bus.gnt),       32'(e.gnt));
        check_field(e.name, "owner",     32'(bus.owner),     32'(e.owner));
        check_field(e.name, "net_out",   32'(bus.net_out),   32'(e.net));
        check_field(e.name, "net_valid", 32'(bus.net_valid), 32'(e.valid));
        check_field(e.name, "busy",      32'(bus.busy),      32'(e.busy));
        check_field(e.name, "tmo_pulse", 32'(bus.tmo_pulse), 32'(e.tmo));
        check_field(e.name, "gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'(1));
        check_field(e.name, "valid_has_gnt",
                    32'(!bus.net_valid || (bus.gnt != '0)), 32'(1));
    endtask

    task automatic applyStimulus(input vec_t v);
        vec_t e;
        rst         = v.rst;
        bus.req     = v.req;
        bus.rel     = v.rel;
        bus.data_in = v.data;
        scoreboard.push_back(v);
        @(posedge clk);
        #1;
        e = scoreboard.pop_front();
        checkOutput(e);
    endtask

    initial begin
        logic [31:0] base;
        logic [31:0] alt;
        logic [7:0]  held;
        logic [7:0]  d;
        int          order [5];

        tests_run    = 0;
        tests_failed = 0;
        base  = 32'h3CA5_2110;
        alt   = 32'h3CA5_2177;
        order = '{0, 1, 2, 3, 0};

        rst         = 1'b1;
        bus.req     = '0;
        bus.rel     = '0;
        bus.data_in = base;

        // Reset held for three cycles while everyone requests.
        for (int i = 0; i < 3; i++)
            add_vec("reset", 1, 4'hF, 4'h0, base, 4'h0, 2'd0, 8'h00, 0, 0, 0);

        // Single requester 2: grant, five valid cycles, release, turnaround, idle.
        add_vec("single_grant", 0, 4'b0100, 4'h0, base, 4'b0100, 2'd2, 8'h00, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            add_vec("single_hold", 0, 4'b0100, (i == 2) ? 4'b1011 : 4'h0, base,
                    4'b0100, 2'd2, 8'hA5, 1, 1, 0);
        add_vec("single_rel",  0, 4'b0100, 4'b0100, base, 4'h0, 2'd2, 8'hA5, 0, 1, 0);
        add_vec("single_idle", 0, 4'b0000, 4'h0,    base, 4'h0, 2'd2, 8'hA5, 0, 0, 0);

        // ptr now 3: owner 3 releases with req=1001, ptr wraps, 0 wins next.
        add_vec("wrap_grant3", 0, 4'b1001, 4'h0,    base, 4'b1000, 2'd3, 8'hA5, 0, 1, 0);
        add_vec("wrap_hold3",  0, 4'b1001, 4'h0,    base, 4'b1000, 2'd3, 8'h3C, 1, 1, 0);
        add_vec("wrap_rel3",   0, 4'b1001, 4'b1000, base, 4'h0,    2'd3, 8'h3C, 0, 1, 0);
        add_vec("wrap_grant0", 0, 4'b1001, 4'h0,    base, 4'b0001, 2'd0, 8'h3C, 0, 1, 0);
        add_vec("wrap_hold0",  0, 4'b1001, 4'h0,    base, 4'b0001, 2'd0, 8'h10, 1, 1, 0);
        add_vec("live_data",   0, 4'b1001, 4'h0,    alt,  4'b0001, 2'd0, 8'h77, 1, 1, 0);
        add_vec("req_drop0",   0, 4'b1000, 4'h0,    alt,  4'h0,    2'd0, 8'h77, 0, 1, 0);
        add_vec("grant3_again",0, 4'b1000, 4'h0,    base, 4'b1000, 2'd3, 8'h77, 0, 1, 0);
        add_vec("hold3_again", 0, 4'b1000, 4'h0,    base, 4'b1000, 2'd3, 8'h3C, 1, 1, 0);
        add_vec("req_drop3",   0, 4'b0000, 4'h0,    base, 4'h0,    2'd3, 8'h3C, 0, 1, 0);
        add_vec("idle_again",  0, 4'b0000, 4'h0,    base, 4'h0,    2'd3, 8'h3C, 0, 0, 0);

        // Reset during HOLD of owner 1, then ptr=0 picks 1 over 3.
        add_vec("pre_rst_grant", 0, 4'b0010, 4'h0, base, 4'b0010, 2'd1, 8'h3C, 0, 1, 0);
        add_vec("pre_rst_hold",  0, 4'b0010, 4'h0, base, 4'b0010, 2'd1, 8'h21, 1, 1, 0);
        add_vec("mid_reset",     1, 4'b0010, 4'h0, base, 4'h0,    2'd0, 8'h00, 0, 0, 0);
        add_vec("post_rst_grant",0, 4'b1010, 4'h0, base, 4'b0010, 2'd1, 8'h00, 0, 1, 0);
        add_vec("post_rst_hold", 0, 4'b1010, 4'h0, base, 4'b0010, 2'd1, 8'h21, 1, 1, 0);
        add_vec("post_rst_drop", 0, 4'b1000, 4'h0, base, 4'h0,    2'd1, 8'h21, 0, 1, 0);
        add_vec("post_rst_idle", 0, 4'b0000, 4'h0, base, 4'h0,    2'd1, 8'h21, 0, 0, 0);

        // Fairness: all four request, each owner releases after two valid cycles.
        add_vec("fair_reset", 1, 4'hF, 4'h0, base, 4'h0, 2'd0, 8'h00, 0, 0, 0);
        held = 8'h00;
        for (int h = 0; h < 5; h++) begin
            d = base[order[h]*8 +: 8];
            add_vec("fair_grant", 0, 4'hF, 4'h0, base, 4'(1 << order[h]), 2'(order[h]),
                    held, 0, 1, 0);
            add_vec("fair_hold1", 0, 4'hF, 4'h0, base, 4'(1 << order[h]), 2'(order[h]),
                    d, 1, 1, 0);
            add_vec("fair_hold2", 0, 4'hF, 4'h0, base, 4'(1 << order[h]), 2'(order[h]),
                    d, 1, 1, 0);
            add_vec("fair_turn", 0, 4'hF, 4'(1 << order[h]), base, 4'h0, 2'(order[h]),
                    d, 0, 1, 0);
            held = d;
        end
        add_vec("fair_idle", 0, 4'h0, 4'h0, base, 4'h0, 2'd0, 8'h10, 0, 0, 0);

`ifdef ARB_TIMEOUT_EN
        // Owner 0 never releases: sixteen valid cycles, one pulse, then 2 wins.
        add_vec("tmo_reset", 1, 4'h0, 4'h0, base, 4'h0, 2'd0, 8'h00, 0, 0, 0);
        add_vec("tmo_grant", 0, 4'b0101, 4'h0, base, 4'b0001, 2'd0, 8'h00, 0, 1, 0);
        for (int i = 0; i < TMO_MAX; i++)
            add_vec("tmo_hold", 0, 4'b0101, 4'h0, base, 4'b0001, 2'd0, 8'h10, 1, 1, 0);
        add_vec("tmo_turn",   0, 4'b0101, 4'h0, base, 4'h0,    2'd0, 8'h10, 0, 1, 1);
        add_vec("tmo_next",   0, 4'b0101, 4'h0, base, 4'b0100, 2'd2, 8'h10, 0, 1, 0);
        add_vec("tmo_hold2",  0, 4'b0101, 4'h0, base, 4'b0100, 2'd2, 8'hA5, 1, 1, 0);
        add_vec("tmo_rel2",   0, 4'b0000, 4'b0100, base, 4'h0, 2'd2, 8'hA5, 0, 1, 0);
        add_vec("tmo_idle",   0, 4'b0000, 4'h0, base, 4'h0,    2'd2, 8'hA5, 0, 0, 0);
`endif

        foreach (vecs[i])
            applyStimulus(vecs[i]);

        check_field("scoreboard", "pending", 32'(scoreboard.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
